// File: rtl/definitions.sv
// rtl/definitions.sv - shared types and constants for the SECDED Hamming decoder
package definitions;

    typedef enum logic [1:0] {ST_LO, ST_HI, ST_CALC, ST_OUT} hamState_t;

    localparam logic [1:0] kHAM_CLEAN  = 2'b00;
    localparam logic [1:0] kHAM_FIXED  = 2'b01;
    localparam logic [1:0] kHAM_DOUBLE = 2'b10;

    // Hamming positions of data bits b1..b11, in order
    localparam logic [3:0] kDATA_POS [11] = '{4'd3, 4'd5, 4'd6, 4'd7, 4'd9, 4'd10,
                                              4'd11, 4'd12, 4'd13, 4'd14, 4'd15};

    function automatic logic [10:0] extractData(input logic [15:0] cw);
        logic [10:0] d;
        d = '0;
        for (int i = 0; i < 11; i++) begin
            d[i] = cw[kDATA_POS[i]];
        end
        return d;
    endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// rtl/hamming_syndrome.sv - combinational syndrome and overall parity of a 16-bit codeword
module hamming_syndrome (
    input  logic [15:0] cw,
    output logic [3:0]  s,
    output logic        P
);

    always_comb begin
        s = '0;
        for (int i = 0; i < 16; i++) begin
            for (int k = 0; k < 4; k++) begin
                if (i[k]) s[k] = s[k] ^ cw[i];
            end
        end
    end

    assign P = ^cw;

endmodule

// File: rtl/hamming_decoder.sv
// rtl/hamming_decoder.sv - byte-serial SECDED decoder with saturating error statistics
module hamming_decoder
    import definitions::*;
#(
    parameter int STAT_W = 8
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              inValid,
    output logic              inReady,
    input  logic [7:0]        inByte,
    output logic              outValid,
    input  logic              outReady,
    output logic [10:0]       outData,
    output logic [1:0]        outStatus,
    input  logic              clrStats,
    output logic [STAT_W-1:0] numCorrected,
    output logic [STAT_W-1:0] numDouble
);

    hamState_t   state, nextState;
    logic [15:0] cw;
    logic [15:0] fixedCw;
    logic [3:0]  syn;
    logic        parity;
    logic [10:0] calcData;
    logic [1:0]  calcStatus;
    logic        handoff;

    hamming_syndrome uSyndrome (
        .cw (cw),
        .s  (syn),
        .P  (parity)
    );

    // An odd overall parity means exactly one bit flipped; s==0 points at p0 itself
    assign fixedCw = cw ^ (16'd1 << syn);

    always_comb begin
        calcData   = extractData(cw);
        calcStatus = kHAM_CLEAN;
        if (parity) begin
            calcData   = extractData(fixedCw);
            calcStatus = kHAM_FIXED;
        end else if (syn != 4'd0) begin
            calcStatus = kHAM_DOUBLE;
        end
    end

    always_comb begin
        nextState = state;
        inReady   = 1'b0;
        outValid  = 1'b0;
        case (state)
            ST_LO: begin
                inReady = 1'b1;
                if (inValid) nextState = ST_HI;
            end
            ST_HI: begin
                inReady = 1'b1;
                if (inValid) nextState = ST_CALC;
            end
            ST_CALC: nextState = ST_OUT;
            ST_OUT: begin
                outValid = 1'b1;
                if (outReady) nextState = ST_LO;
            end
            default: nextState = ST_LO;
        endcase
    end

    assign handoff = (state == ST_OUT) && outReady;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= ST_LO;
            cw        <= '0;
            outData   <= '0;
            outStatus <= kHAM_CLEAN;
        end else begin
            state <= nextState;
            if (state == ST_LO && inValid) cw[7:0]  <= inByte;
            if (state == ST_HI && inValid) cw[15:8] <= inByte;
            if (state == ST_CALC) begin
                outData   <= calcData;
                outStatus <= calcStatus;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            numCorrected <= '0;
            numDouble    <= '0;
        end else if (clrStats) begin
            numCorrected <= '0;
            numDouble    <= '0;
        end else if (handoff) begin
            if (outStatus == kHAM_FIXED && numCorrected != '1)
                numCorrected <= numCorrected + STAT_W'(1);
            if (outStatus == kHAM_DOUBLE && numDouble != '1)
                numDouble <= numDouble + STAT_W'(1);
        end
    end

endmodule

// File: tb/tb_hamming_decoder.sv
// tb/tb_hamming_decoder.sv - directed self-checking bench for hamming_decoder
module tb_hamming_decoder;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        inValid;
    logic        inReady;
    logic [7:0]  inByte;
    logic        outValid;
    logic        outReady;
    logic [10:0] outData;
    logic [1:0]  outStatus;
    logic        clrStats;
    logic [1:0]  numCorrected;
    logic [1:0]  numDouble;

    int checks   = 0;
    int failures = 0;

    hamming_decoder #(.STAT_W(2)) dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .inValid      (inValid),
        .inReady      (inReady),
        .inByte       (inByte),
        .outValid     (outValid),
        .outReady     (outReady),
        .outData      (outData),
        .outStatus    (outStatus),
        .clrStats     (clrStats),
        .numCorrected (numCorrected),
        .numDouble    (numDouble)
    );

    always #5 Clk = ~Clk;

    task automatic expectEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic loadWord(input logic [7:0] lo, input logic [7:0] hi, input int gap);
        inValid = 1'b1;
        inByte  = lo;
        tick();
        inValid = 1'b0;
        inByte  = 8'hxx;
        repeat (gap) tick();
        inValid = 1'b1;
        inByte  = hi;
        tick();
        inValid = 1'b0;
        inByte  = 8'h00;
    endtask

    task automatic awaitResult(input string tag);
        int n;
        n = 0;
        expectEq({tag, "_calc_inReady"}, 32'(inReady), 32'd0);
        while (!outValid && n < 8) begin
            tick();
            n++;
        end
        expectEq({tag, "_latency"}, n, 1);
    endtask

    task automatic runWord(input string tag, input logic [7:0] lo, input logic [7:0] hi,
                           input int gap, input logic [10:0] expData, input logic [1:0] expStatus,
                           input logic [1:0] expNc, input logic [1:0] expNd);
        loadWord(lo, hi, gap);
        awaitResult(tag);
        expectEq({tag, "_data"}, 32'(outData), 32'(expData));
        expectEq({tag, "_status"}, 32'(outStatus), 32'(expStatus));
        outReady = 1'b1;
        tick();
        outReady = 1'b0;
        expectEq({tag, "_valid_drop"}, 32'(outValid), 32'd0);
        expectEq({tag, "_numCorrected"}, 32'(numCorrected), 32'(expNc));
        expectEq({tag, "_numDouble"}, 32'(numDouble), 32'(expNd));
    endtask

    initial begin
        Reset_n  = 1'b0;
        inValid  = 1'b0;
        inByte   = 8'h00;
        outReady = 1'b0;
        clrStats = 1'b0;
        repeat (2) tick();
        expectEq("rst_inReady", 32'(inReady), 32'd1);
        expectEq("rst_outValid", 32'(outValid), 32'd0);
        expectEq("rst_outData", 32'(outData), 32'd0);
        expectEq("rst_outStatus", 32'(outStatus), 32'd0);
        expectEq("rst_numCorrected", 32'(numCorrected), 32'd0);
        expectEq("rst_numDouble", 32'(numDouble), 32'd0);
        Reset_n = 1'b1;
        tick();

        runWord("clean",  8'h0F, 8'h00, 0, 11'h001, 2'b00, 2'd0, 2'd0);
        runWord("single", 8'h0F, 8'h04, 0, 11'h001, 2'b01, 2'd1, 2'd0);
        runWord("p0err",  8'h0E, 8'h00, 0, 11'h001, 2'b01, 2'd2, 2'd0);
        runWord("double", 8'h2F, 8'h04, 0, 11'h023, 2'b10, 2'd2, 2'd1);

        // Backpressure: result must sit unchanged while outReady stays low
        loadWord(8'h0F, 8'h04, 0);
        awaitResult("bp");
        for (int i = 0; i < 5; i++) begin
            tick();
            expectEq("bp_outValid", 32'(outValid), 32'd1);
            expectEq("bp_inReady", 32'(inReady), 32'd0);
            expectEq("bp_data", 32'(outData), 32'h001);
            expectEq("bp_status", 32'(outStatus), 32'd1);
        end
        outReady = 1'b1;
        tick();
        outReady = 1'b0;
        expectEq("bp_numCorrected", 32'(numCorrected), 32'd3);

        runWord("gap",   8'h2F, 8'h04, 3, 11'h023, 2'b10, 2'd3, 2'd2);
        runWord("satNc", 8'h0F, 8'h04, 0, 11'h001, 2'b01, 2'd3, 2'd2);

        // Reset while waiting for the high byte
        inValid = 1'b1;
        inByte  = 8'h0F;
        tick();
        inValid = 1'b0;
        Reset_n = 1'b0;
        #1;
        expectEq("rstHi_inReady", 32'(inReady), 32'd1);
        expectEq("rstHi_numCorrected", 32'(numCorrected), 32'd0);
        expectEq("rstHi_numDouble", 32'(numDouble), 32'd0);
        tick();
        Reset_n = 1'b1;
        tick();
        runWord("afterRstHi", 8'h0F, 8'h00, 0, 11'h001, 2'b00, 2'd0, 2'd0);

        // Reset while a result is presented: outputs clear at once
        loadWord(8'h0F, 8'h04, 0);
        awaitResult("rstOut");
        Reset_n = 1'b0;
        #1;
        expectEq("rstOut_outValid", 32'(outValid), 32'd0);
        expectEq("rstOut_outData", 32'(outData), 32'd0);
        expectEq("rstOut_outStatus", 32'(outStatus), 32'd0);
        tick();
        Reset_n = 1'b1;
        tick();
        expectEq("rstOut_numCorrected", 32'(numCorrected), 32'd0);

        for (int i = 1; i <= 5; i++) begin
            runWord("sat5", 8'h0F, 8'h04, 0, 11'h001, 2'b01, (i > 3) ? 2'd3 : 2'(i), 2'd0);
        end

        clrStats = 1'b1;
        tick();
        clrStats = 1'b0;
        expectEq("clr_numCorrected", 32'(numCorrected), 32'd0);

        // clrStats wins over an increment on the same handshake
        loadWord(8'h0F, 8'h04, 0);
        awaitResult("clrPri");
        outReady = 1'b1;
        clrStats = 1'b1;
        tick();
        outReady = 1'b0;
        clrStats = 1'b0;
        expectEq("clrPri_numCorrected", 32'(numCorrected), 32'd0);
        expectEq("clrPri_inReady", 32'(inReady), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
